// File: rtl/sd_dat_pkg.sv
// Shared constants and types for the DAT-line read/write data paths.
// Bit positions describe a captured single-bit-mode block packet.
package sd_dat_pkg;

    localparam int unsigned DATA_BYTES = 512;
    localparam int unsigned CRC_W      = 16;
    localparam int unsigned DATA_W     = DATA_BYTES * 8;
    localparam int unsigned PKT_W      = 1 + DATA_W + CRC_W + 1;

    localparam int unsigned START_BIT = 4113;
    localparam int unsigned DATA_MSB  = 4112;
    localparam int unsigned DATA_LSB  = 17;
    localparam int unsigned CRC_MSB   = 16;
    localparam int unsigned CRC_LSB   = 1;
    localparam int unsigned END_BIT   = 0;

    localparam logic [15:0] CRC16_POLY = 16'h1021;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT,
        ST_CHECK
    } rd_state_e;

endpackage

// File: rtl/dat_rd_unpack_if.sv
// Packet-in / byte-stream-out bundle of the read unpacker.
// master is the unpacker side, slave the receiver plus block-buffer side.
interface dat_rd_unpack_if;
    import sd_dat_pkg::*;

    logic             new_rd_pkt_strb;
    logic [PKT_W-1:0] rd_pkt;
    logic [7:0]       byte_out;
    logic             byte_vld;
    logic             byte_rdy;
    logic [8:0]       byte_idx;
    logic             busy;
    logic             blk_done_strb;
    logic             crc_ok;
    logic             crc_err;
    logic             frm_err;
    logic             pkt_drop;

    modport master (
        input  new_rd_pkt_strb, rd_pkt, byte_rdy,
        output byte_out, byte_vld, byte_idx, busy, blk_done_strb,
               crc_ok, crc_err, frm_err, pkt_drop
    );

    modport slave (
        output new_rd_pkt_strb, rd_pkt, byte_rdy,
        input  byte_out, byte_vld, byte_idx, busy, blk_done_strb,
               crc_ok, crc_err, frm_err, pkt_drop
    );

endinterface

// File: rtl/sd_crc16_byte.sv
// Combinational CRC16-CCITT update over one byte, MSB first.
// Shared by the read checker and the write-path CRC generator.
module sd_crc16_byte (
    input  logic [15:0] crc_in,
    input  logic [7:0]  d,
    output logic [15:0] crc_out
);
    import sd_dat_pkg::*;

    logic [15:0] c;

    always_comb begin
        c = crc_in;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[15] ^ d[7 - i]) begin
                c = {c[14:0], 1'b0} ^ CRC16_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/dat_rd_unpack.sv
// Unpacks a captured read block into a byte stream, checks framing and CRC16,
// and reports sticky status with a one-cycle completion strobe.
module dat_rd_unpack (
    input logic             sd_clk,
    input logic             reset,
    dat_rd_unpack_if.master bus
);
    import sd_dat_pkg::*;

    localparam logic [8:0] LAST_IDX = 9'(DATA_BYTES - 1);

    rd_state_e         state, state_nxt;
    logic [DATA_W-1:0] data_reg;
    logic [CRC_W-1:0]  rx_crc;
    logic [CRC_W-1:0]  crc_acc;
    logic [CRC_W-1:0]  crc_nxt;
    logic [8:0]        byte_idx;
    logic              crc_ok, crc_err, frm_err, pkt_drop;
    logic              load, accept;
    logic [7:0]        cur_byte;

    assign cur_byte = data_reg[DATA_W-1 -: 8];

    sd_crc16_byte u_crc (
        .crc_in  (crc_acc),
        .d       (cur_byte),
        .crc_out (crc_nxt)
    );

    always_ff @(posedge sd_clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // byte_out is forced to zero outside EMIT so the all-ones idle register never leaks out
    always_comb begin
        state_nxt         = state;
        load              = 1'b0;
        accept            = 1'b0;
        bus.byte_out      = '0;
        bus.byte_vld      = 1'b0;
        bus.busy          = 1'b0;
        bus.blk_done_strb = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.new_rd_pkt_strb) begin
                    load      = 1'b1;
                    state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                bus.busy     = 1'b1;
                bus.byte_vld = 1'b1;
                bus.byte_out = cur_byte;
                accept       = bus.byte_rdy;
                if (accept && (byte_idx == LAST_IDX)) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                bus.busy          = 1'b1;
                bus.blk_done_strb = 1'b1;
                state_nxt         = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sd_clk) begin
        if (reset) begin
            data_reg <= '1;
            rx_crc   <= '1;
            crc_acc  <= '0;
            byte_idx <= '0;
            crc_ok   <= 1'b0;
            crc_err  <= 1'b0;
            frm_err  <= 1'b0;
            pkt_drop <= 1'b0;
        end else begin
            pkt_drop <= bus.new_rd_pkt_strb && (state != ST_IDLE);
            if (load) begin
                data_reg <= bus.rd_pkt[DATA_MSB:DATA_LSB];
                rx_crc   <= bus.rd_pkt[CRC_MSB:CRC_LSB];
                frm_err  <= bus.rd_pkt[START_BIT] || !bus.rd_pkt[END_BIT];
                crc_ok   <= 1'b0;
                crc_err  <= 1'b0;
                crc_acc  <= '0;
                byte_idx <= '0;
            end
            if (accept) begin
                data_reg <= {data_reg[DATA_W-9:0], 8'hFF};
                crc_acc  <= crc_nxt;
                byte_idx <= byte_idx + 9'd1;
            end
            if (state == ST_CHECK) begin
                crc_ok  <= (crc_acc == rx_crc);
                crc_err <= (crc_acc != rx_crc);
            end
        end
    end

    assign bus.byte_idx = byte_idx;
    assign bus.crc_ok   = crc_ok;
    assign bus.crc_err  = crc_err;
    assign bus.frm_err  = frm_err;
    assign bus.pkt_drop = pkt_drop;

endmodule

// File: doc/dat_rd_unpack.md
Name: dat_rd_unpack

Overview:
- Downstream consumer of the DAT-line serial receiver.
- Takes one captured single-bit-mode read packet (start bit, 512 data bytes, CRC16, end bit) on its ready strobe and checks framing.
- Streams the 512 bytes out MSB-first through a valid/ready handshake to the block buffer.
- Computes CRC16-CCITT over the data, compares it with the received CRC, and reports a one-cycle completion strobe with sticky status.

Parameters:
- PKT_W, 4114, total packet width in bits (1 start + DATA_BYTES*8 + CRC_W + 1 end).
- DATA_BYTES, 512, number of data bytes per block.
- CRC_W, 16, CRC field width in bits.

Ports:
- sd_clk  in  1  SD clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- new_rd_pkt_strb  in  1  one-cycle pulse; rd_pkt is valid this cycle.
- rd_pkt  in  PKT_W  captured packet. Bit 4113 = start, [4112:17] = data MSB-first, [16:1] = CRC16, [0] = end.
- byte_out  out  8  current data byte.
- byte_vld  out  1  byte_out is valid.
- byte_rdy  in  1  consumer accepts byte_out when byte_vld && byte_rdy.
- byte_idx  out  9  index of byte_out, 0..511.
- busy  out  1  packet being unpacked.
- blk_done_strb  out  1  one-cycle pulse; status is final.
- crc_ok  out  1  sticky: computed CRC == received CRC.
- crc_err  out  1  sticky: CRC mismatch.
- frm_err  out  1  sticky: start bit != 0 or end bit != 1.
- pkt_drop  out  1  one-cycle pulse; strobe arrived while busy and was ignored.

Behaviour:
- Reset values:
  - state IDLE.
  - byte_out 0, byte_vld 0, byte_idx 0, busy 0.
  - blk_done_strb 0, crc_ok 0, crc_err 0, frm_err 0, pkt_drop 0.
  - Internal packet register all 1s; CRC accumulator 0.
- States: IDLE, EMIT, CHECK.
- IDLE, on new_rd_pkt_strb at edge k:
  - data register <= rd_pkt[4112:17]; rx_crc <= rd_pkt[16:1].
  - frm_err <= (rd_pkt[4113] != 0) || (rd_pkt[0] != 1).
  - crc_ok, crc_err <= 0; crc_acc <= 0x0000; byte_idx <= 0.
  - state <= EMIT.
  - byte_vld and busy are high from cycle k+1.
- EMIT:
  - byte_out = top 8 bits of the data register; byte_vld = 1.
  - On accept: data register shifts left 8; crc_acc <= crc16_byte(crc_acc, byte_out); byte_idx increments.
  - No accept means all values hold. byte_vld stays high until the byte is taken; never withdrawn.
  - Accept with byte_idx == 511: state <= CHECK; byte_vld drops next cycle; byte_idx wraps to 0.
- CHECK (one cycle):
  - crc_ok <= (crc_acc == rx_crc); crc_err <= !that.
  - blk_done_strb = 1 for exactly this cycle.
  - state <= IDLE; busy falls with the strobe.
- Frame errors do not abort. All 512 bytes are still emitted, and frm_err is reported alongside crc status.
- Latency:
  - Strobe to first byte_vld: 1 cycle.
  - With byte_rdy tied high, strobe to blk_done_strb: 513 cycles. Byte 0 is valid at k+1, the last accept occurs at k+512, and CHECK runs at k+513.
- CRC: CRC16-CCITT, polynomial x^16+x^12+x^5+1 (0x1021), init 0x0000, no reflection, no final XOR. Processes 8 bits per accept, MSB first.
- Simultaneous events:
  - Strobe in EMIT or CHECK: packet ignored, pkt_drop pulses 1 cycle, current packet unaffected.
  - Strobe in the same cycle as the CHECK-to-IDLE transition is also dropped. The upstream guarantees spacing of at least 4114 cycles.
- Status persistence: crc_ok, crc_err and frm_err hold until the next accepted strobe or reset.
- Reset mid-operation: immediate return to IDLE with reset values. No blk_done_strb is issued and partial output is abandoned.

Decomposition:
- Shared package sd_dat_pkg holds:
  - PKT_W, DATA_BYTES, CRC_W.
  - Bit-position constants START_BIT = 4113, DATA_MSB = 4112, DATA_LSB = 17, CRC_MSB = 16, CRC_LSB = 1, END_BIT = 0.
  - CRC16_POLY = 16'h1021.
  - State enum.
- One sub-module, sd_crc16_byte: combinational 8-bit-per-step CRC16 update with inputs crc_in[15:0] and d[7:0] and output crc_out[15:0]. It is shared with the write-path CRC generator.

Test Plan:
- All-0xFF data, CRC field 0x7FA1, start 0, end 1, byte_rdy = 1:
  - 512 bytes of 0xFF with byte_idx 0..511.
  - blk_done_strb at strobe+513.
  - crc_ok = 1, crc_err = 0, frm_err = 0.
- All-zero data, CRC 0x0000, valid framing, byte_rdy toggled 1-of-3 cycles: every byte emitted exactly once in order, byte_vld never drops mid-block, crc_ok = 1.
- Incrementing data (byte i = i mod 256) with CRC field corrupted to 0x0000: bytes 0x00..0xFF repeated twice, crc_err = 1, crc_ok = 0.
- Valid data but start bit 1 and end bit 0: all 512 bytes still emitted, frm_err = 1, crc_ok = 1.
- Second strobe at byte_idx = 100: pkt_drop pulses 1 cycle, the first packet completes unchanged with its original status.
- Reset asserted at byte_idx = 300:
  - Next cycle: byte_vld = 0, busy = 0, all status 0, no blk_done_strb.
  - A fresh packet afterwards unpacks correctly from byte_idx 0.
